// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks (write and read side).
// Gray conversions work on a 32-bit container. Callers zero-extend their pointer
// and then truncate the result back to their own width. Zero-extension does not
// change the low bits of either conversion, so one function pair serves every
// pointer width.
package fifo_pkg;

    localparam int unsigned FIFO_ADDR_SIZE = 32'd6;
    localparam int unsigned FIFO_DEPTH     = 32'd1 << FIFO_ADDR_SIZE;

    // Binary to reflected Gray code.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 32'd1);
    endfunction

    // Reflected Gray code to binary: each bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin     = 32'd0;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/wptr_full.sv
// Write-side pointer and status block of the asynchronous FIFO (wclk domain).
// This block keeps a binary write pointer with an extra wrap bit and a registered
// Gray copy for the read-domain synchroniser. It derives full, almost-full, the
// fill level and a sticky overflow flag by comparing against the read pointer,
// which is already synchronised into wclk. Full is computed from the next-state
// pointer, so the write that fills the last slot also raises wfull on the same edge.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE    = FIFO_ADDR_SIZE,
    parameter int unsigned AFULL_THRESH = 32'd56
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wcount,
    output logic                 wovf
);

    localparam int unsigned PTR_W = ADDR_SIZE + 32'd1;

    logic [PTR_W-1:0] wbin_q,   wbin_d;
    logic [PTR_W-1:0] wptr_q,   wptr_d;
    logic [PTR_W-1:0] wcount_q, wcount_d;
    logic             wfull_q,  wfull_d;
    logic             wafull_q, wafull_d;
    logic             wovf_q,   wovf_d;

    logic             accept_s;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] full_cmp_s;

    // Next-state computation: write acceptance, pointer advance, full/level/overflow.
    always_comb begin
        accept_s   = winc & ~wfull_q;
        wbin_d     = wbin_q + PTR_W'(accept_s);
        wptr_d     = PTR_W'(bin2gray(32'(wbin_d)));
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        // In Gray code that means the top two bits differ and the rest match.
        full_cmp_s = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};
        wfull_d    = (wptr_d == full_cmp_s);
        rbin_s     = PTR_W'(gray2bin(32'(wq2_rptr)));
        // Write and read-pointer movement in the same cycle are both folded in here.
        wcount_d   = wbin_d - rbin_s;
        wafull_d   = (32'(wcount_d) >= AFULL_THRESH);
        // A write attempted while full is dropped and remembered until reset.
        wovf_d     = wovf_q | (winc & wfull_q);
    end

    // State registers; reset clears all history at once, without waiting for a clock edge.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wcount_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wcount_q <= wcount_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    // The memory address comes straight from the binary pointer register.
    assign waddr        = wbin_q[ADDR_SIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wcount       = wcount_q;
    assign wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full: table-driven segments plus hand-written
// sequences for asynchronous reset, fill, pointer wrap and a simultaneous read/write.
module tb_wptr_full;

    logic       wclk;
    logic       wrst;
    logic       winc;
    logic [6:0] wq2_rptr;
    logic [5:0] waddr;
    logic [6:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [6:0] wcount;
    logic       wovf;

    int checks = 0;
    int errors = 0;

    wptr_full #(.ADDR_SIZE(6), .AFULL_THRESH(56)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wcount       (wcount),
        .wovf         (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        int         cyc;
        logic       winc;
        logic [6:0] rptr;
        logic [5:0] e_waddr;
        logic [6:0] e_wptr;
        logic       e_full;
        logic       e_af;
        logic [6:0] e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [6:0] g7(input logic [6:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge wclk);
        #1;
        winc     = 1'b0;
        wq2_rptr = 7'h00;
        wrst     = 1'b1;
        #6;
        wrst     = 1'b0;
    endtask

    // The Gray write pointer may change by at most one bit per clock outside reset.
    logic [6:0] prev_wptr;
    logic       prev_valid = 1'b0;
    always @(negedge wclk) begin
        if (!wrst && prev_valid) begin
            checks++;
            if ($countones(prev_wptr ^ wptr) > 1) begin
                errors++;
                $display("FAIL gray_step actual=%0h->%0h required one-bit change", prev_wptr, wptr);
            end
        end
        prev_wptr  = wptr;
        prev_valid = !wrst;
    end

    logic [6:0] m;
    logic [6:0] r;

    initial begin
        wrst     = 1'b1;
        winc     = 1'b0;
        wq2_rptr = 7'h00;
        #12;
        wrst     = 1'b0;
        #1;
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wptr",  32'(wptr),  32'd0);
        chk("rst_full",  32'(wfull), 32'd0);
        chk("rst_af",    32'(walmost_full), 32'd0);
        chk("rst_cnt",   32'(wcount), 32'd0);
        chk("rst_ovf",   32'(wovf),  32'd0);

        // Fill from empty: the address steps 0..63 and the 64th write sets full.
        @(posedge wclk);
        #1;
        winc = 1'b1;
        for (int i = 0; i < 64; i++) begin
            chk("fill_waddr", 32'(waddr), 32'(i));
            chk("fill_full_low", 32'(wfull), 32'd0);
            step();
        end
        winc = 1'b0;
        chk("fill_full", 32'(wfull), 32'd1);
        chk("fill_wptr", 32'(wptr), 32'h60);
        chk("fill_cnt",  32'(wcount), 32'd64);
        chk("fill_waddr_end", 32'(waddr), 32'd0);

        // Mid-stream asynchronous reset after 10 writes, checked before any clock edge.
        do_reset();
        winc = 1'b1;
        for (int i = 0; i < 10; i++) step();
        winc = 1'b0;
        chk("pre_rst_waddr", 32'(waddr), 32'd10);
        #1;
        wrst = 1'b1;
        #1;
        chk("arst_waddr", 32'(waddr), 32'd0);
        chk("arst_wptr",  32'(wptr),  32'd0);
        chk("arst_full",  32'(wfull), 32'd0);
        chk("arst_cnt",   32'(wcount), 32'd0);
        chk("arst_ovf",   32'(wovf),  32'd0);
        #4;
        wrst = 1'b0;
        winc = 1'b1;
        chk("post_rst_waddr0", 32'(waddr), 32'd0);
        step();
        winc = 1'b0;
        chk("post_rst_waddr1", 32'(waddr), 32'd1);
        chk("post_rst_wptr1",  32'(wptr),  32'd1);

        // Table: almost-full threshold, full, overflow, release and refill.
        tbl[0] = '{55, 1'b1, 7'h00, 6'd55, 7'h2C, 1'b0, 1'b0, 7'd55, 1'b0};
        tbl[1] = '{1,  1'b1, 7'h00, 6'd56, 7'h24, 1'b0, 1'b1, 7'd56, 1'b0};
        tbl[2] = '{8,  1'b1, 7'h00, 6'd0,  7'h60, 1'b1, 1'b1, 7'd64, 1'b0};
        tbl[3] = '{3,  1'b1, 7'h00, 6'd0,  7'h60, 1'b1, 1'b1, 7'd64, 1'b1};
        tbl[4] = '{1,  1'b0, 7'h00, 6'd0,  7'h60, 1'b1, 1'b1, 7'd64, 1'b1};
        tbl[5] = '{1,  1'b0, 7'h01, 6'd0,  7'h60, 1'b0, 1'b1, 7'd63, 1'b1};
        tbl[6] = '{1,  1'b1, 7'h01, 6'd1,  7'h61, 1'b1, 1'b1, 7'd64, 1'b1};
        tbl[7] = '{1,  1'b0, 7'h61, 6'd1,  7'h61, 1'b0, 1'b0, 7'd0,  1'b1};
        do_reset();
        for (int v = 0; v < 8; v++) begin
            winc     = tbl[v].winc;
            wq2_rptr = tbl[v].rptr;
            for (int c = 0; c < tbl[v].cyc; c++) step();
            chk($sformatf("tbl%0d_waddr", v), 32'(waddr),        32'(tbl[v].e_waddr));
            chk($sformatf("tbl%0d_wptr", v),  32'(wptr),         32'(tbl[v].e_wptr));
            chk($sformatf("tbl%0d_full", v),  32'(wfull),        32'(tbl[v].e_full));
            chk($sformatf("tbl%0d_af", v),    32'(walmost_full), 32'(tbl[v].e_af));
            chk($sformatf("tbl%0d_cnt", v),   32'(wcount),       32'(tbl[v].e_cnt));
            chk($sformatf("tbl%0d_ovf", v),   32'(wovf),         32'(tbl[v].e_ovf));
        end

        // Wrap: the read pointer trails the write pointer by 4 through 200 writes.
        do_reset();
        winc = 1'b1;
        for (int i = 0; i < 4; i++) step();
        m = 7'd4;
        for (int k = 0; k < 200; k++) begin
            wq2_rptr = g7(m - 7'd3);
            step();
            m = m + 7'd1;
            chk("wrap_wptr",  32'(wptr),   32'(g7(m)));
            chk("wrap_waddr", 32'(waddr),  32'(m[5:0]));
            chk("wrap_cnt",   32'(wcount), 32'd4);
            chk("wrap_full",  32'(wfull),  32'd0);
        end
        chk("wrap_end_waddr", 32'(waddr), 32'd12);

        // Simultaneous: bring the level to 10, then write while the read pointer advances.
        r = m - 7'd4;
        for (int i = 0; i < 6; i++) step();
        m = m + 7'd6;
        chk("sim_pre_cnt", 32'(wcount), 32'd10);
        r        = r + 7'd1;
        wq2_rptr = g7(r);
        step();
        m = m + 7'd1;
        chk("sim_cnt",  32'(wcount), 32'd10);
        chk("sim_wptr", 32'(wptr),   32'(g7(m)));
        winc     = 1'b0;
        r        = r + 7'd1;
        wq2_rptr = g7(r);
        step();
        chk("sim_read_only_cnt", 32'(wcount), 32'd9);
        chk("sim_ovf", 32'(wovf), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
